// File: rtl/display_capture.sv
// display_capture: snoops CPU register-file writes to one watched register and
// presents a rate-limited, optionally saturated 16-bit half of the captured
// value to a 4-digit seven-segment driver.
//
// Ports:
//   clock_100Mhz      in   1   system clock
//   reset             in   1   synchronous, active-high reset
//   reg_write         in   1   register-file write enable
//   write_reg         in   5   destination register index
//   write_data        in  32   write-back data
//   page_btn          in   1   raw push-button; each debounced press toggles page_sel
//   freeze_sw         in   1   raw switch; 1 holds the current display
//   displayed_number  out 16   value shown on the display
//   page_sel          out  1   0 = captured[15:0], 1 = captured[31:16]
//   overflow          out  1   selected half exceeded 9999 at the last update
//   update_pulse      out  1   one-cycle strobe when displayed_number is loaded
module display_capture #(
    parameter logic [4:0]  WATCH_REG       = 5'd10,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned UPDATE_DIV_BITS = 18,
    parameter bit          SATURATE        = 1'b1
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic        reg_write,
    input  logic [4:0]  write_reg,
    input  logic [31:0] write_data,
    input  logic        page_btn,
    input  logic        freeze_sw,
    output logic [15:0] displayed_number,
    output logic        page_sel,
    output logic        overflow,
    output logic        update_pulse
);

    localparam int unsigned DB_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    // x0 is hardwired to zero, so watching it means capture is disabled
    localparam bit          CAPTURE_EN = (WATCH_REG != 5'd0);
    localparam logic [15:0] MAX_SHOWN  = 16'd9999;

    logic [31:0]                r_captured;
    logic                       r_btn_s1;
    logic                       r_btn_s2;
    logic                       r_frz_s1;
    logic                       r_frz_s2;
    logic [DB_W-1:0]            r_db_cnt;
    logic                       r_db_level;
    logic                       r_db_level_d;
    logic                       r_page_sel;
    logic [UPDATE_DIV_BITS-1:0] r_div;
    logic [15:0]                r_displayed;
    logic                       r_overflow;
    logic                       r_update_pulse;

    logic                       w_btn_rise;
    logic                       w_tick;
    logic [15:0]                w_half;
    logic                       w_ovf;
    logic [15:0]                w_sat;

    // Register-file snoop: last write to the watched register wins
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            r_captured <= 32'd0;
        end else if (CAPTURE_EN && reg_write && (write_reg == WATCH_REG)) begin
            r_captured <= write_data;
        end
    end

    // Two-flop synchronisers for the raw button and switch
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
            r_frz_s1 <= 1'b0;
            r_frz_s2 <= 1'b0;
        end else begin
            r_btn_s1 <= page_btn;
            r_btn_s2 <= r_btn_s1;
            r_frz_s1 <= freeze_sw;
            r_frz_s2 <= r_frz_s1;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES differing cycles
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            r_db_cnt     <= '0;
            r_db_level   <= 1'b0;
            r_db_level_d <= 1'b0;
        end else begin
            r_db_level_d <= r_db_level;
            if (r_btn_s2 == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_MAX) begin
                r_db_level <= r_btn_s2;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    assign w_btn_rise = r_db_level & ~r_db_level_d;

    // Press (not release) toggles the page
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            r_page_sel <= 1'b0;
        end else if (w_btn_rise) begin
            r_page_sel <= ~r_page_sel;
        end
    end

    // Half selection and saturation from registered state only
    always_comb begin
        w_half = r_page_sel ? r_captured[31:16] : r_captured[15:0];
        w_ovf  = (w_half > MAX_SHOWN);
        w_sat  = (SATURATE && w_ovf) ? MAX_SHOWN : w_half;
    end

    assign w_tick = &r_div;

    // Free-running update divider and display load on tick unless frozen
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            r_div          <= '0;
            r_displayed    <= 16'd0;
            r_overflow     <= 1'b0;
            r_update_pulse <= 1'b0;
        end else begin
            r_div          <= r_div + UPDATE_DIV_BITS'(1);
            r_update_pulse <= 1'b0;
            if (w_tick && !r_frz_s2) begin
                r_displayed    <= w_sat;
                r_overflow     <= w_ovf;
                r_update_pulse <= 1'b1;
            end
        end
    end

    assign displayed_number = r_displayed;
    assign page_sel         = r_page_sel;
    assign overflow         = r_overflow;
    assign update_pulse     = r_update_pulse;

endmodule

// File: doc/display_capture.md
Name: display_capture

Overview:
- Sits directly upstream of the 4-digit seven-segment driver. Produces the 16-bit binary `displayed_number` that the driver decodes digit by digit.
- Snoops CPU register-file writes and captures every 32-bit write to one watched register.
- A debounced push-button selects which 16-bit half is shown.
- Values above 9999 saturate, since the display has only four decimal digits.
- Output updates are rate-limited to a fixed tick, and can be frozen by a switch, so the display does not flicker while the program runs.

Parameters:
- WATCH_REG, 5'd10: register-file index to capture. A value of 0 disables capture, because x0 is hardwired to zero.
- DEBOUNCE_CYCLES, 1000000: number of stable clock cycles required to accept a button level change (10 ms at 100 MHz).
- UPDATE_DIV_BITS, 18: width of the update divider. An update tick occurs every 2^UPDATE_DIV_BITS cycles.
- SATURATE, 1: 1 clamps values above 9999 to 9999; 0 passes the raw half through.

Ports:
- clock_100Mhz  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- reg_write  in  1  CPU register-file write enable.
- write_reg  in  5  CPU destination register index.
- write_data  in  32  CPU write-back data.
- page_btn  in  1  raw, asynchronous push-button. Each press toggles the displayed half.
- freeze_sw  in  1  raw slide switch. 1 holds the current display.
- displayed_number  out  16  value presented to the seven-segment driver.
- page_sel  out  1  0 selects captured[15:0]; 1 selects captured[31:16].
- overflow  out  1  the selected half exceeded 9999 at the last update.
- update_pulse  out  1  one-cycle strobe when displayed_number is loaded.

Behaviour:
- Clocking and reset:
  - Single clock, clock_100Mhz. All state updates on its rising edge.
  - reset is synchronous and active-high.
  - On reset, all of the following go to 0: captured, displayed_number, page_sel, overflow, update_pulse, the divider, the debounce counter, the synchronisers and the debounced level.
  - Reset asserted mid-debounce or mid-divide aborts the operation. No update_pulse is issued on the cycle reset is high.
- Capture:
  - When reg_write=1 and write_reg=WATCH_REG and WATCH_REG!=0, captured <= write_data on that edge.
  - Any other write is ignored.
  - Back-to-back writes: the last one wins.
- Synchronisers and button debounce:
  - page_btn and freeze_sw each pass through 2-flop synchronisers.
  - Debounce counter behaviour:
    - Increments while the synchronised button differs from the debounced level.
    - Clears to 0 whenever they match.
    - On reaching DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the new value and the counter clears.
  - A 0->1 transition of the debounced level toggles page_sel on the next edge.
  - Release (1->0) has no effect.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Selection and saturation (combinational from registered state):
  - half = page_sel ? captured[31:16] : captured[15:0].
  - ovf = (half > 16'd9999), evaluated regardless of SATURATE.
  - sat = (SATURATE && ovf) ? 16'd9999 : half.
- Update:
  - The divider is free-running, UPDATE_DIV_BITS wide, and wraps from all-ones to 0.
  - The tick is the cycle in which the divider is all ones.
  - On a tick with synchronised freeze_sw=0: displayed_number <= sat, overflow <= ovf, update_pulse <= 1.
  - update_pulse is 0 on every other cycle.
  - On a tick with freeze_sw=1: displayed_number, overflow and update_pulse are unchanged/0. The divider keeps running.
- Simultaneous events:
  - A capture write or page toggle on the same edge as a tick is not reflected at that tick. The old registered value is used; the new value appears at the following tick.
- Latency:
  - From a capture write to the display: 1 to 2^UPDATE_DIV_BITS+1 cycles.
  - From a button press to the display: 2 sync cycles + DEBOUNCE_CYCLES + up to one tick period.
- displayed_number only changes on update_pulse cycles. The downstream driver may sample it at any time.

Test Plan (simulate with DEBOUNCE_CYCLES=4, UPDATE_DIV_BITS=4):
- Capture and update:
  - Stimulus: after reset, write reg 10 = 32'h0000_04D2.
  - Required: at the next tick, displayed_number=1234, overflow=0, and update_pulse is high for exactly 1 cycle.
  - Also: a write to reg 11 = 5678 leaves the value at 1234.
- Saturation:
  - Stimulus: write reg 10 = 32'h0000_C350 (50000).
  - Required: displayed_number=9999, overflow=1.
  - Repeat with SATURATE=0: displayed_number=50000, overflow=1.
- Page select and debounce:
  - Stimulus: captured = 32'h0007_0003. Press page_btn for 10 cycles.
  - Required: page_sel=1 and displayed_number=7 after the next tick.
  - Stimulus: a 2-cycle glitch pulse.
  - Required: page_sel is unchanged.
- Freeze:
  - Stimulus: display shows 1234; set freeze_sw=1; write 42.
  - Required: no update_pulse and the display holds 1234 over 3 ticks.
  - Stimulus: clear freeze_sw.
  - Required: 42 is shown at the next tick.
- Collision:
  - Stimulus: write 55 on the exact tick edge.
  - Required: the old value is loaded on that tick; 55 is loaded at the next tick (16 cycles later).
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle during debounce counting and with page_sel=1.
  - Required: all outputs are 0, page_sel=0, and the divider restarts so the first tick occurs 16 cycles after reset deasserts.
